hash_match_scan: RTL

HASH_MATCH_SCAN -- requirements
Module: hash_match_scan

---
 rtl/hash_match_scan.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hash_match_scan.sv
// Sequential associative lookup: a small table of valid-tagged entries is scanned
// one entry per cycle for the first (lowest-index) valid entry equal to a latched key.
module hash_match_scan #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    parameter int IW    = 3
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          WrEn,
    input  logic [IW-1:0] WrAddr,
    input  logic [N-1:0]  WrData,
    input  logic          Clear,
    input  logic          Start,
    input  logic [N-1:0]  Key,
    output logic          Busy,
    output logic          Done,
    output logic          Hit,
    output logic [IW-1:0] HitIdx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state, stateNext;

    logic [N-1:0]    entryData [DEPTH];
    logic [DEPTH-1:0] entryValid;

    logic [N-1:0]  keyReg, keyNext;
    logic [IW-1:0] scanIdx, scanIdxNext;
    logic          hitReg, hitNext;
    logic [IW-1:0] hitIdxReg, hitIdxNext;

    logic isIdle;
    logic tableWr;
    logic tableClr;
    logic match;
    logic lastIdx;

    // The table only changes in IDLE, so a search always sees a frozen snapshot.
    assign isIdle   = (state == IDLE);
    assign tableClr = isIdle & Clear;
    assign tableWr  = isIdle & WrEn & ~Clear;

    assign match   = entryValid[scanIdx] & ~|(entryData[scanIdx] ^ keyReg);
    assign lastIdx = (scanIdx == IW'(DEPTH - 1));

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        stateNext   = state;
        keyNext     = keyReg;
        scanIdxNext = scanIdx;
        hitNext     = hitReg;
        hitIdxNext  = hitIdxReg;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    stateNext   = SCAN;
                    keyNext     = Key;
                    scanIdxNext = '0;
                    hitNext     = 1'b0;
                    hitIdxNext  = '0;
                end
            end
            SCAN: begin
                if (match) begin
                    stateNext  = DONE;
                    hitNext    = 1'b1;
                    hitIdxNext = scanIdx;
                end else if (lastIdx) begin
                    stateNext  = DONE;
                    hitNext    = 1'b0;
                    hitIdxNext = '0;
                end else begin
                    scanIdxNext = scanIdx + IW'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            keyReg    <= '0;
            scanIdx   <= '0;
            hitReg    <= 1'b0;
            hitIdxReg <= '0;
        end else begin
            state     <= stateNext;
            keyReg    <= keyNext;
            scanIdx   <= scanIdxNext;
            hitReg    <= hitNext;
            hitIdxReg <= hitIdxNext;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            entryValid <= '0;
        end else if (tableClr) begin
            entryValid <= '0;
        end else if (tableWr) begin
            entryValid[WrAddr] <= 1'b1;
        end
    end

    // NOTE: the data array has no reset; the valid bits alone decide whether an
    // entry can match, which keeps the storage a plain register file.
    always_ff @(posedge Clk) begin
        if (tableWr) begin
            entryData[WrAddr] <= WrData;
        end
    end

    assign Busy   = (state == SCAN);
    assign Done   = (state == DONE);
    assign Hit    = hitReg;
    assign HitIdx = hitIdxReg;

endmodule
